// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM state encoding and the iteration-count helper.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // One quotient bit is resolved per iteration, so a WIDTH-bit divide
  // needs exactly WIDTH CALC cycles.
  function automatic int div_iter(input int width);
    return width;
  endfunction

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = div_iter(DIV_WIDTH);

endpackage

// File: rtl/seq_divider_sub.sv
// div_sub_stage: combinational trial subtractor a - b computed as a + ~b + 1
// with CLA_BITS-wide carry-lookahead groups.
// Ports:
//   a, b       WIDTH-bit operands
//   diff       WIDTH-bit wrap-around difference
//   no_borrow  carry out of the top group (1 when a >= b)
module div_sub_stage #(
  parameter int WIDTH    = 32,
  parameter int CLA_BITS = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             no_borrow
);
  localparam int NG = WIDTH / CLA_BITS;

  logic [WIDTH-1:0] g, p;
  logic [NG-1:0]    grp_g, grp_p;
  logic [NG:0]      grp_c;   // carry into each group; grp_c[NG] is carry-out

  assign g = a & ~b;
  assign p = a ^ ~b;

  // Group generate/propagate over one CLA_BITS slice.
  function automatic logic [1:0] grp_gp(input logic [CLA_BITS-1:0] gb,
                                        input logic [CLA_BITS-1:0] pb);
    logic gg, gp;
    gg = 1'b0;
    gp = 1'b1;
    for (int i = 0; i < CLA_BITS; i++) begin
      gg = gb[i] | (pb[i] & gg);
      gp = gp & pb[i];
    end
    return {gg, gp};
  endfunction

  // Lookahead across groups; the +1 of the two's complement is the carry-in.
  always_comb begin
    grp_c[0] = 1'b1;
    for (int k = 0; k < NG; k++)
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
  end

  for (genvar k = 0; k < NG; k++) begin : g_grp
    logic [CLA_BITS-1:0] gb, pb, cb;
    assign gb = g[k*CLA_BITS +: CLA_BITS];
    assign pb = p[k*CLA_BITS +: CLA_BITS];
    assign {grp_g[k], grp_p[k]} = grp_gp(gb, pb);

    always_comb begin
      cb[0] = grp_c[k];
      for (int i = 1; i < CLA_BITS; i++)
        cb[i] = gb[i-1] | (pb[i-1] & cb[i-1]);
    end

    assign diff[k*CLA_BITS +: CLA_BITS] = pb ^ cb;
  end

  assign no_borrow = grp_c[NG];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider (DIV/DIVU).
// Ports:
//   clk, resetn            clock, async active-low reset
//   div_start, div_signed  request (taken only when idle) and signedness
//   dividend, divisor      operands, sampled on an accepted start
//   div_cancel             flush; aborts CALC/FIX, blocks a start in IDLE
//   div_busy, div_done     operation in flight / one-cycle result pulse
//   quotient, remainder    results, held until the next completed divide
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CLA_BITS = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             div_cancel,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int ITER = div_iter(WIDTH);
  localparam int CW   = $clog2(ITER + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;      // dividend magnitude; quotient bits shift in at LSB
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH-1:0] part;     // partial remainder
  logic             q_sign, r_sign, dz;
  logic [WIDTH-1:0] q_res, r_res;

  logic             accept, fire, take, no_borrow;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff, q_fix, r_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                           input logic             s);
    return (s & x[WIDTH-1]) ? -x : x;
  endfunction

  assign accept  = (state == ST_IDLE) & div_start & ~div_cancel;
  assign shifted = {part, dvd[WIDTH-1]};

  div_sub_stage #(.WIDTH(WIDTH), .CLA_BITS(CLA_BITS)) u_sub (
    .a         (shifted[WIDTH-1:0]),
    .b         (dvs),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  // A set bit above WIDTH means the shifted partial already exceeds any
  // WIDTH-bit divisor; the wrapped low bits of the difference are exact.
  assign take = shifted[WIDTH] | no_borrow;

  // Divide by zero naturally leaves |dividend| in part, so the remainder
  // sign fix restores the original dividend; only the quotient is forced.
  assign q_fix = dz ? '1 : (q_sign ? -dvd : dvd);
  assign r_fix = r_sign ? -part : part;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_CALC;
      ST_CALC: begin
        if (div_cancel)          state_nxt = ST_IDLE;
        else if (cnt == CW'(1))  state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: the FIX cycle presents the fixed-up result directly so it is
  // valid alongside div_done; a cancel in FIX suppresses both.
  always_comb begin
    div_busy  = (state != ST_IDLE);
    fire      = (state == ST_FIX) & ~div_cancel;
    div_done  = fire;
    quotient  = fire ? q_fix : q_res;
    remainder = fire ? r_fix : r_res;
  end

  // Datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      part   <= '0;
      q_sign <= 1'b0;
      r_sign <= 1'b0;
      dz     <= 1'b0;
      q_res  <= '0;
      r_res  <= '0;
    end else begin
      if (accept) begin
        dvd    <= mag(dividend, div_signed);
        dvs    <= mag(divisor, div_signed);
        part   <= '0;
        q_sign <= (dividend[WIDTH-1] ^ divisor[WIDTH-1]) & div_signed;
        r_sign <= dividend[WIDTH-1] & div_signed;
        dz     <= (divisor == '0);
        cnt    <= CW'(ITER);
      end else if (state == ST_CALC) begin
        part <= take ? diff : shifted[WIDTH-1:0];
        dvd  <= {dvd[WIDTH-2:0], take};
        cnt  <= cnt - CW'(1);
      end
      if (fire) begin
        q_res <= q_fix;
        r_res <= r_fix;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver pushes hand-computed results,
// a negedge monitor pops and compares on every div_done.
module tb_seq_divider;
  localparam int W = 32;

  logic         clk = 1'b0, resetn = 1'b0;
  logic         div_start = 1'b0, div_signed = 1'b0, div_cancel = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         div_busy, div_done;
  logic [W-1:0] quotient, remainder;

  int errors = 0, checks = 0, cyc = 0;
  logic [W-1:0] last_q = '0, last_r = '0;

  typedef struct { logic [W-1:0] q; logic [W-1:0] r; int at; } exp_t;
  exp_t sb[$];

  seq_divider #(.WIDTH(W), .CLA_BITS(4)) dut (
    .clk(clk), .resetn(resetn), .div_start(div_start), .div_signed(div_signed),
    .dividend(dividend), .divisor(divisor), .div_cancel(div_cancel),
    .div_busy(div_busy), .div_done(div_done),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (div_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("done_cycle", W'(cyc), W'(e.at));
      end
    end
  end

  // One full operation; inj>0 pulses a second start (50/7) that must be ignored.
  task automatic op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] q, input logic [W-1:0] r, input int inj = 0);
    exp_t e;
    @(negedge clk);
    div_signed = sgn; dividend = a; divisor = b; div_start = 1'b1;
    e.q = q; e.r = r; e.at = cyc + W + 1;
    sb.push_back(e);
    @(negedge clk);
    div_start = 1'b0; dividend = ~a; divisor = ~b; div_signed = ~sgn;
    chk("busy_first", W'(div_busy), W'(1));
    for (int i = 2; i <= W + 2; i++) begin
      @(negedge clk);
      div_start = (i == inj);
      if (i == inj) begin dividend = 50; divisor = 7; end
      if (i == W) begin
        chk("q_hold", quotient, last_q);
        chk("r_hold", remainder, last_r);
      end
      if (i == W + 1) chk("busy_last", W'(div_busy), W'(1));
      if (i == W + 2) chk("busy_after", W'(div_busy), W'(0));
    end
    last_q = q; last_r = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(div_busy), W'(0));
    chk("rst_done", W'(div_done), W'(0));
    chk("rst_q", quotient, '0);
    chk("rst_r", remainder, '0);
    resetn = 1'b1;

    op(1'b0, 32'd100,       32'd7,          32'd14,         32'd2);
    op(1'b1, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF);
    op(1'b1, 32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1);
    op(1'b0, 32'hFFFFFFF9,  32'd2,          32'h7FFFFFFC,   32'd1);
    op(1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   32'd0);
    op(1'b0, 32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,   32'd0);
    op(1'b1, 32'd5,         32'd0,          32'hFFFFFFFF,   32'd5);
    op(1'b1, 32'hFFFFFFFB,  32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB);
    op(1'b1, 32'hFFFFFF9C,  32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE);
    op(1'b0, 32'h12345678,  32'h00001000,   32'h00012345,   32'h00000678);
    op(1'b0, 32'd1000,      32'd10,         32'd100,        32'd0, 5);

    // Cancel mid-CALC with start held high, then cancel+start together in IDLE.
    @(negedge clk);
    div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; div_start = 1'b1;
    repeat (10) @(negedge clk);
    div_cancel = 1'b1;
    @(negedge clk);
    chk("cancel_busy", W'(div_busy), W'(0));
    chk("cancel_q", quotient, last_q);
    chk("cancel_r", remainder, last_r);
    @(negedge clk);
    chk("cancel_wins", W'(div_busy), W'(0));
    div_start = 1'b0; div_cancel = 1'b0;

    op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // Reset mid-operation discards it.
    @(negedge clk);
    div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    repeat (14) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid_rst_q", quotient, '0);
    chk("mid_rst_r", remainder, '0);
    chk("mid_rst_busy", W'(div_busy), W'(0));
    chk("mid_rst_done", W'(div_done), W'(0));
    @(negedge clk);
    resetn = 1'b1;
    last_q = '0; last_r = '0;

    op(1'b0, 32'd3, 32'd5, 32'd0, 32'd3);

    repeat (4) @(negedge clk);
    chk("pending_done", W'(sb.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle radix-2 restoring integer divider for the CPU execute stage; serves DIV/DIVU and writes HI/LO.
- It is the inverse counterpart of the carry-lookahead adder datapath. Each iteration performs one trial subtraction: carry-lookahead add of the inverted divisor with carry-in 1.
- Quotient and remainder are produced WIDTH+1 cycles after an accepted start and held until the next start.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, >=4)
- CLA_BITS, 4, group size of the lookahead blocks in the trial subtractor (must divide WIDTH)

Ports:
- clk  input  1  clock, rising-edge
- resetn  input  1  asynchronous active-low reset
- div_start  input  1  request; accepted only when div_busy=0
- div_signed  input  1  1=DIV (two's complement), 0=DIVU; sampled with div_start
- dividend  input  WIDTH  sampled on accepted start
- divisor  input  WIDTH  sampled on accepted start
- div_cancel  input  1  pipeline flush; aborts an operation in progress
- div_busy  output  1  high while an operation is in progress
- div_done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  WIDTH  result quotient (to LO)
- remainder  output  WIDTH  result remainder (to HI)

Behaviour:
- Reset (async, resetn=0): state=IDLE; div_busy=0, div_done=0, quotient=0, remainder=0, counter=0. Reset asserted mid-operation discards the operation with no done pulse.
- States:
  - IDLE: div_start=1 and div_cancel=0 -> CALC. The block latches |dividend| and |divisor| (absolute values only when div_signed=1), the quotient sign (dividend[MSB]^divisor[MSB]) & div_signed, the remainder sign dividend[MSB] & div_signed, and a divide-by-zero flag. The partial remainder is cleared and counter=WIDTH.
  - CALC: one iteration per cycle. The partial remainder shifts left with the next dividend MSB shifted in, then trial diff = partial - |divisor| through the CLA subtractor. If there is no borrow (carry-out=1): partial=diff and the quotient bit is 1; otherwise the quotient bit is 0. counter decrements. counter reaching 0 -> FIX.
  - FIX: the quotient is negated if its sign bit is set and the remainder is negated if its sign bit is set. Results are registered, div_done=1 for this single cycle, then -> IDLE.
- Latency: start accepted at cycle T -> div_done at T+WIDTH+1. div_busy=1 from T+1 through T+WIDTH+1 inclusive.
- div_start while busy is ignored; there is no queueing.
- div_start in the FIX cycle is ignored (div_busy=1).
- div_cancel in CALC or FIX -> IDLE next cycle. No done pulse; quotient/remainder keep their previous values.
- div_cancel and div_start together in IDLE: cancel wins and nothing is accepted.
- Divide by zero: the full latency is taken. Result is quotient={WIDTH{1'b1}} and remainder=dividend (original value), regardless of div_signed. No exception is raised.
- Signed overflow (MIN_INT / -1): quotient=MIN_INT, remainder=0. This falls out of unsigned magnitude arithmetic.
- quotient/remainder change only in FIX (or on reset) and hold stable otherwise.
- Signed results: remainder sign follows the dividend; the quotient truncates toward zero.
- All arithmetic is WIDTH-bit wrap-around. The subtractor is WIDTH+1 bits wide internally only to expose the borrow.

Decomposition:
- Shared package holds the state encoding constants (ST_IDLE=2'd0, ST_CALC=2'd1, ST_FIX=2'd2) and the DIV_ITER constant derived from WIDTH.
- One sub-module, div_sub_stage: combinational WIDTH-bit subtractor built from CLA_BITS-wide lookahead groups. It computes a + ~b + 1 and outputs the difference and no_borrow.
- The FSM, counter, shift registers and sign fix-up stay in seq_divider.

Test Plan:
- Unsigned 100/7 start at cycle 0 -> div_done at cycle 33; quotient=14, remainder=2; div_busy high cycles 1..33.
- Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
- Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Divide by zero: signed 5/0 -> quotient=0xFFFFFFFF, remainder=5, done at cycle 33.
- Start 100/7, hold div_start high, assert div_cancel at cycle 10 -> no div_done, div_busy=0 at cycle 11, outputs unchanged. Then start 9/3 -> quotient=3, remainder=0.
- Drop resetn at cycle 15 of an operation -> outputs 0 immediately, no div_done. A second start issued while busy is ignored: exactly one div_done occurs.
